// File: rtl/vga_palette_mux.sv
// Two-stage pixel decoder: palette lookup for drawn pixels, grayscale expansion for camera pixels,
// with hsync/vsync/blank delayed to match. Define BLINK_EN to flash tag 2'b10 pixels at a frame-counted rate.
module vga_palette_mux #(
  parameter int unsigned PIX_W        = 8,
  parameter int unsigned TAG_W        = 2,
  parameter int unsigned PAL_IDX_W    = 2,
  parameter int unsigned CH_W         = 4,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [PIX_W-1:0]       pixel_in,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  input  logic                   blank_in,
  input  logic                   pal_we_in,
  input  logic [PAL_IDX_W-1:0]   pal_addr_in,
  input  logic [3*CH_W-1:0]      pal_data_in,
  output logic [3*CH_W-1:0]      pixel_out,
  output logic                   hsync_out,
  output logic                   vsync_out,
  output logic                   blank_out
);

  localparam int unsigned RGB_W     = 3 * CH_W;
  localparam int unsigned PAL_DEPTH = 2 ** PAL_IDX_W;
  localparam int unsigned REM_W     = PIX_W - TAG_W;
  localparam int unsigned EXT_W     = REM_W + CH_W;

  // Place a 4-bit reference nibble in the MSBs of a CH_W-bit channel.
  function automatic logic [CH_W-1:0] nib_to_ch(input logic [3:0] nib);
    logic [CH_W+3:0] wide;
    wide = {nib, {CH_W{1'b0}}};
    return CH_W'(wide >> 4);
  endfunction

  function automatic logic [RGB_W-1:0] pal_default(input int unsigned idx);
    logic [CH_W-1:0]  ones;
    logic [CH_W-1:0]  zeros;
    logic [RGB_W-1:0] val;
    ones  = '1;
    zeros = '0;
    case (idx)
      0:       val = {zeros, zeros, ones};
      1:       val = {ones, ones, zeros};
      2:       val = {nib_to_ch(4'hA), nib_to_ch(4'h2), nib_to_ch(4'h6)};
      default: val = {ones, ones, ones};
    endcase
    return val;
  endfunction

  logic [RGB_W-1:0]     pal_q [PAL_DEPTH];

  logic [TAG_W-1:0]     tag_c;
  logic [EXT_W-1:0]     gray_ext;
  logic [CH_W-1:0]      gray_c;

  logic [CH_W-1:0]      s1_gray;
  logic [PAL_IDX_W-1:0] s1_idx;
  logic                 s1_pal;
  logic                 s1_hsync;
  logic                 s1_vsync;
  logic                 s1_blank;

  logic                 use_pal;
  logic [RGB_W-1:0]     pix_nxt;

  // Grayscale level: CH_W bits below the tag, zero-filled at the LSB end when the pixel is short.
  assign tag_c    = pixel_in[PIX_W-1 -: TAG_W];
  assign gray_ext = {pixel_in[REM_W-1:0], {CH_W{1'b0}}};
  assign gray_c   = CH_W'(gray_ext >> REM_W);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int unsigned i = 0; i < PAL_DEPTH; i++) begin
        pal_q[i] <= pal_default(i);
      end
    end else if (pal_we_in) begin
      pal_q[pal_addr_in] <= pal_data_in;
    end
  end

`ifdef BLINK_EN
  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic             s1_alt;
  logic             vsync_q;
  logic             phase_q;
  logic [CNT_W-1:0] frame_cnt_q;

  // Frame counter advances on vsync rising edges, so the phase only ever flips at frame start.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      vsync_q     <= 1'b0;
      phase_q     <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      vsync_q <= vsync_in;
      if (vsync_in && !vsync_q) begin
        if (frame_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
          frame_cnt_q <= '0;
          phase_q     <= ~phase_q;
        end else begin
          frame_cnt_q <= frame_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s1_alt <= 1'b0;
    end else begin
      s1_alt <= (tag_c == TAG_W'(2));
    end
  end
`endif

  // Stage 1: capture pixel attributes and sideband.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s1_gray  <= '0;
      s1_idx   <= '0;
      s1_pal   <= 1'b0;
      s1_hsync <= 1'b0;
      s1_vsync <= 1'b0;
      s1_blank <= 1'b1;
    end else begin
      s1_gray  <= gray_c;
      s1_idx   <= pixel_in[PAL_IDX_W-1:0];
      s1_pal   <= (tag_c == {TAG_W{1'b1}});
      s1_hsync <= hsync_in;
      s1_vsync <= vsync_in;
      s1_blank <= blank_in;
    end
  end

  // Stage 2 select; palette read sees the pre-write contents on a same-cycle write.
  always_comb begin
    use_pal = s1_pal;
`ifdef BLINK_EN
    use_pal = s1_pal | (s1_alt & phase_q);
`endif
    pix_nxt = {s1_gray, s1_gray, s1_gray};
    if (s1_blank) begin
      pix_nxt = '0;
    end else if (use_pal) begin
      pix_nxt = pal_q[s1_idx];
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pixel_out <= '0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      blank_out <= 1'b1;
    end else begin
      pixel_out <= pix_nxt;
      hsync_out <= s1_hsync;
      vsync_out <= s1_vsync;
      blank_out <= s1_blank;
    end
  end

endmodule
